// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings and reader state type
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/axi_stream_reg.sv
// rtl/axi_stream_reg.sv - one-entry registered valid/ready slice
module axi_stream_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  input  logic             s_tlast_i,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic             m_tlast_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  // Ready while empty or draining, so a pop and a push can share one cycle.
  assign s_tready_o = !valid_q || m_tready_i;

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (s_tvalid_i && s_tready_o) begin
      data_d  = s_tdata_i;
      last_d  = s_tlast_i;
      valid_d = 1'b1;
    end else if (m_tready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign m_tdata_o  = data_q;
  assign m_tlast_o  = last_q;
  assign m_tvalid_o = valid_q;

endmodule

// File: rtl/axi_master_burst_reader.sv
// rtl/axi_master_burst_reader.sv - single INCR burst AXI read initiator
module axi_master_burst_reader
  import axi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
  parameter int MAX_SIZE      = $clog2(STROBE_WIDTH)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [2:0]               cmd_size,
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     error
);

  localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);

  state_e                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                 len_q, len_d;
  logic [2:0]                 size_q, size_d;
  logic [8:0]                 expected_q, expected_d;
  logic [8:0]                 count_q, count_d;
  logic                       error_q, error_d;
  logic                       done_q, done_d;

  logic [8:0]                 count_inc;
  logic                       beat_last;
  logic                       slice_in_valid;
  logic                       slice_in_ready;

  assign count_inc = count_q + 9'd1;
  assign beat_last = (count_inc == expected_q);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    size_d         = size_q;
    expected_d     = expected_q;
    count_d        = count_q;
    error_d        = error_q;
    done_d         = 1'b0;
    cmd_ready      = 1'b0;
    arvalid        = 1'b0;
    rready         = 1'b0;
    slice_in_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          size_d  = cmd_size;
          count_d = '0;
          error_d = 1'b0;
          if (cmd_size > MAX_SIZE_L) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          expected_d = {1'b0, len_q} + 9'd1;
          count_d    = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        rready         = slice_in_ready;
        slice_in_valid = rvalid;
        if (rvalid && slice_in_ready) begin
          count_d = count_inc;
          // A misplaced or missing rlast is flagged but never shortens the burst.
          if ((rresp != RESP_OKAY) || (rlast != beat_last)) begin
            error_d = 1'b1;
          end
          if (beat_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!out_valid || out_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      expected_q <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      expected_q <= expected_d;
      count_q    <= count_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  axi_stream_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_out_slice (
    .clk_i      (aclk),
    .rst_i      (areset),
    .s_tdata_i  (rdata),
    .s_tlast_i  (beat_last),
    .s_tvalid_i (slice_in_valid),
    .s_tready_o (slice_in_ready),
    .m_tdata_o  (out_data),
    .m_tlast_o  (out_last),
    .m_tvalid_o (out_valid),
    .m_tready_i (out_ready)
  );

  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = BURST_INCR;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_axi_master_burst_reader.sv
// tb/tb_axi_master_burst_reader.sv - scoreboard bench for axi_master_burst_reader
module tb_axi_master_burst_reader;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [7:0]  araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic        error;

  axi_master_burst_reader dut (
    .aclk      (aclk),
    .areset    (areset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_size  (cmd_size),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .error     (error)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          ar_hs_cnt = 0;
  logic [7:0]  exp_addr;
  logic [7:0]  exp_len;
  logic [2:0]  exp_size;
  logic [31:0] beat_data [0:7];
  logic [1:0]  beat_resp [0:7];
  logic        beat_rlast[0:7];
  int          or_mode = 0;
  int          or_idx = 0;
  logic [3:0]  or_pat = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // out_ready driver: constant 1 or the repeating pattern 1,0,0,1
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (or_mode == 0) begin
        out_ready = 1'b1;
      end else begin
        out_ready = or_pat[3 - (or_idx % 4)];
        or_idx++;
      end
    end
  end

  // Monitor: pops the scoreboard on every output transfer and checks AR fields
  initial begin
    beat_t b;
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_beat", 64'(out_data), 64'hFFFF_FFFF_FFFF);
          end else begin
            b = exp_q.pop_front();
            check("out_data", 64'(out_data), 64'(b.d));
            check("out_last", 64'(out_last), 64'(b.l));
          end
        end
        if (out_valid && !out_ready) check("rready_when_full", 64'(rready), 64'd0);
        if (done) done_cnt++;
        if (arvalid && arready) begin
          ar_hs_cnt++;
          check("araddr", 64'(araddr), 64'(exp_addr));
          check("arlen", 64'(arlen), 64'(exp_len));
          check("arsize", 64'(arsize), 64'(exp_size));
          check("arburst", 64'(arburst), 64'd1);
        end
      end
    end
  end

  task automatic issue_cmd(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size);
    int t;
    exp_addr = addr;
    exp_len  = len;
    exp_size = size;
    @(posedge aclk);
    #1;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_valid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!cmd_ready && t < 50) begin
      @(negedge aclk);
      t++;
    end
    if (!cmd_ready) check("timeout_cmd_ready", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drive_beat(input int i);
    int t;
    rvalid = 1'b1;
    rdata  = beat_data[i];
    rresp  = beat_resp[i];
    rlast  = beat_rlast[i];
    t = 0;
    @(negedge aclk);
    while (!rready && t < 50) begin
      @(negedge aclk);
      t++;
    end
    if (!rready) check("timeout_rready", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic run_cmd(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input int ar_delay, input logic exp_err);
    int t;
    int hs0;
    beat_t b;
    hs0 = ar_hs_cnt;
    if (size <= 3'd2) begin
      for (int i = 0; i <= int'(len); i++) begin
        b.d = beat_data[i];
        b.l = (i == int'(len));
        exp_q.push_back(b);
      end
    end
    issue_cmd(addr, len, size);
    if (size > 3'd2) begin
      for (int c = 1; c <= 3; c++) begin
        @(negedge aclk);
        check("illegal_no_arvalid", 64'(arvalid), 64'd0);
        if (c == 1) check("illegal_done_c1", 64'(done), 64'd0);
        if (c == 2) check("illegal_done_c2", 64'(done), 64'd1);
        if (c == 2) check("illegal_error", 64'(error), 64'd1);
        if (c == 3) check("illegal_done_c3", 64'(done), 64'd0);
      end
      return;
    end
    for (int c = 0; c <= ar_delay; c++) begin
      arready = (c == ar_delay);
      @(negedge aclk);
      if (c == 0) check("error_clear_on_accept", 64'(error), 64'd0);
      check("arvalid_hold", 64'(arvalid), 64'd1);
      @(posedge aclk);
      #1;
    end
    arready = 1'b0;
    check("ar_handshake_once", 64'(ar_hs_cnt - hs0), 64'd1);
    for (int i = 0; i <= int'(len); i++) drive_beat(i);
    t = 0;
    @(negedge aclk);
    while (!done && t < 50) begin
      @(negedge aclk);
      t++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("error_at_done", 64'(error), 64'(exp_err));
    check("all_beats_out", 64'(exp_q.size()), 64'd0);
    @(negedge aclk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    areset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_size  = '0;
    arready   = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_outputs", {arvalid, rready, out_valid, out_last, done, error, araddr, arlen, arsize, out_data}, 64'd0);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // 1: four OKAY beats, arready after 2 cycles
    for (int i = 0; i < 4; i++) begin
      beat_data[i]  = 32'hA0 + 32'(i);
      beat_resp[i]  = 2'b00;
      beat_rlast[i] = (i == 3);
    end
    run_cmd(8'h10, 8'd3, 3'd2, 2, 1'b0);

    // 2: same burst under out_ready backpressure
    or_mode = 1;
    run_cmd(8'h10, 8'd3, 3'd2, 0, 1'b0);
    or_mode = 0;

    // 3: single beat with SLVERR
    beat_data[0]  = 32'h5555_0001;
    beat_resp[0]  = 2'b10;
    beat_rlast[0] = 1'b1;
    run_cmd(8'h20, 8'd0, 3'd2, 1, 1'b1);

    // 4: early rlast on beat 2 of 3
    for (int i = 0; i < 3; i++) begin
      beat_data[i]  = 32'hC0 + 32'(i);
      beat_resp[i]  = 2'b00;
      beat_rlast[i] = (i >= 1);
    end
    run_cmd(8'h33, 8'd2, 3'd1, 0, 1'b1);

    // 5: illegal size
    run_cmd(8'h40, 8'd1, 3'd3, 0, 1'b1);

    // 6: asynchronous reset after the first of four beats
    for (int i = 0; i < 4; i++) begin
      beat_data[i]  = 32'hB0 + 32'(i);
      beat_resp[i]  = 2'b00;
      beat_rlast[i] = (i == 3);
    end
    issue_cmd(8'h50, 8'd3, 3'd2);
    arready = 1'b1;
    @(posedge aclk);
    #1;
    arready = 1'b0;
    rvalid = 1'b1;
    rdata  = beat_data[0];
    @(posedge aclk);
    #1;
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #1;
    areset = 1'b1;
    #1;
    check("async_reset_outputs", {arvalid, rready, out_valid, out_last, done, error, araddr, arlen, arsize, out_data}, 64'd0);
    rvalid = 1'b0;
    exp_q.delete();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    beat_data[0]  = 32'hD0;
    beat_data[1]  = 32'hD1;
    beat_rlast[0] = 1'b0;
    beat_rlast[1] = 1'b1;
    run_cmd(8'h60, 8'd1, 3'd2, 1, 1'b0);

    check("done_pulse_count", 64'(done_cnt), 64'd6);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
